// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master core among three requesters.
// Optional WAIT-state watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transaction, scanning REQ from the round-robin pointer
// GRANT  | GNT asserted, requester fields latched onto M_*
// LAUNCH | waiting for an idle master, then pulse M_START
// WAIT   | transaction in flight on the bus
// DONE   | REQ_DONE/ERR presented, pointer advanced
module i2c_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 48000
) (
   input  logic        CLK_48MHZ,
   input  logic        EXT_RESET,
   input  logic [2:0]  REQ,
   input  logic [20:0] REQ_ADDR,
   input  logic [23:0] REQ_REG,
   input  logic [23:0] REQ_WDATA,
   input  logic [2:0]  REQ_RW,
   output logic [2:0]  GNT,
   output logic [2:0]  REQ_DONE,
   output logic [7:0]  RDATA,
   output logic        ERR,
   output logic        M_START,
   output logic [6:0]  M_ADDR,
   output logic [7:0]  M_REG,
   output logic [7:0]  M_WDATA,
   output logic        M_RW,
   input  logic        M_BUSY,
   input  logic        M_DONE,
   input  logic        M_ACK_ERR,
   input  logic [7:0]  M_RDATA
);

   typedef enum logic [2:0] {ST_IDLE, ST_GRANT, ST_LAUNCH, ST_WAIT, ST_DONE} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt;
`endif

   state_t     state;
   logic [1:0] ptr;
   logic [1:0] cur;
   logic [1:0] win;
   logic [1:0] nxt1;
   logic [1:0] nxt2;

   // first asserted request at or after the pointer, wrapping modulo 3
   always_comb begin
      nxt1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
      nxt2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
      win  = nxt2;
      if (REQ[ptr])
         win = ptr;
      else if (REQ[nxt1])
         win = nxt1;
   end

   always_ff @(posedge CLK_48MHZ or negedge EXT_RESET) begin
      if (!EXT_RESET) begin
         state    <= ST_IDLE;
         ptr      <= 2'd0;
         cur      <= 2'd0;
         GNT      <= 3'b000;
         REQ_DONE <= 3'b000;
         RDATA    <= 8'h00;
         ERR      <= 1'b0;
         M_START  <= 1'b0;
         M_ADDR   <= 7'h00;
         M_REG    <= 8'h00;
         M_WDATA  <= 8'h00;
         M_RW     <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt      <= '0;
`endif
      end else begin
         M_START  <= 1'b0;
         REQ_DONE <= 3'b000;
         case (state)
            ST_IDLE: begin
               if (|REQ) begin
                  cur   <= win;
                  GNT   <= 3'b001 << win;
                  state <= ST_GRANT;
                  case (win)
                     2'd1: begin
                        M_ADDR  <= REQ_ADDR[13:7];
                        M_REG   <= REQ_REG[15:8];
                        M_WDATA <= REQ_WDATA[15:8];
                        M_RW    <= REQ_RW[1];
                     end
                     2'd2: begin
                        M_ADDR  <= REQ_ADDR[20:14];
                        M_REG   <= REQ_REG[23:16];
                        M_WDATA <= REQ_WDATA[23:16];
                        M_RW    <= REQ_RW[2];
                     end
                     default: begin
                        M_ADDR  <= REQ_ADDR[6:0];
                        M_REG   <= REQ_REG[7:0];
                        M_WDATA <= REQ_WDATA[7:0];
                        M_RW    <= REQ_RW[0];
                     end
                  endcase
               end
            end
            ST_GRANT: state <= ST_LAUNCH;
            ST_LAUNCH: begin
               if (!M_BUSY) begin
                  M_START <= 1'b1;
                  state   <= ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                  cnt     <= '0;
`endif
               end
            end
            ST_WAIT: begin
               if (M_DONE) begin
                  REQ_DONE <= GNT;
                  ERR      <= M_ACK_ERR;
                  if (M_RW)
                     RDATA <= M_RDATA;
                  state    <= ST_DONE;
               end
`ifdef I2C_ARB_TIMEOUT_EN
               else if (cnt == CNT_LAST) begin
                  REQ_DONE <= GNT;
                  ERR      <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            ST_DONE: begin
               GNT   <= 3'b000;
               ERR   <= 1'b0;
               ptr   <= (cur == 2'd2) ? 2'd0 : cur + 2'd1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 48000, WAIT-state watchdog limit in clock cycles (1 ms at 48 MHz).
REQ-002 CLK_48MHZ  input  1  system clock; all state updates on its rising edge.
REQ-003 EXT_RESET  input  1  asynchronous, active-low reset.
REQ-004 REQ  input  3  per-requester transaction request, level, bit k = requester k.
REQ-005 REQ_ADDR  input  21  7-bit slave address per requester; bits [7k+6:7k].
REQ-006 REQ_REG  input  24  8-bit register index per requester; bits [8k+7:8k].
REQ-007 REQ_WDATA  input  24  8-bit write data per requester; bits [8k+7:8k].
REQ-008 REQ_RW  input  3  per requester: 1 = read, 0 = write.
REQ-009 GNT  output  3  one-hot grant, held from grant until completion.
REQ-010 REQ_DONE  output  3  one-cycle completion pulse to the granted requester.
REQ-011 RDATA  output  8  read byte; valid in the REQ_DONE cycle and held until the next completion.
REQ-012 ERR  output  1  transaction error (NACK or timeout); valid in the REQ_DONE cycle.
REQ-013 M_START  output  1  one-cycle launch pulse to the I2C master core.
REQ-014 M_ADDR, M_REG, M_WDATA, M_RW  output  7/8/8/1  latched transaction fields to the master core.
REQ-015 M_BUSY, M_DONE, M_ACK_ERR  input  1 each  master status: bus active, one-cycle completion pulse, slave NACK seen.
REQ-016 M_RDATA  input  8  master read byte; valid with M_DONE.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, GRANT, LAUNCH, WAIT, DONE.
REQ-018 IDLE -> GRANT on the first edge where REQ is non-zero; the winner is the first asserted bit at or after the round-robin pointer (pointer 0 checks 0,1,2; pointer 1 checks 1,2,0; pointer 2 checks 2,0,1).
REQ-019 GRANT SHALL last one cycle: assert GNT[k], latch the requester's fields into M_ADDR/M_REG/M_WDATA/M_RW, then go to LAUNCH.
REQ-020 LAUNCH SHALL pulse M_START for exactly one cycle in the first cycle M_BUSY = 0, then go to WAIT; while M_BUSY = 1 it holds with M_START = 0.
REQ-021 WAIT -> DONE on M_DONE = 1: capture M_RDATA into RDATA (reads only; writes leave RDATA unchanged) and set ERR = M_ACK_ERR.
REQ-022 DONE SHALL last one cycle: pulse REQ_DONE[k], drive ERR, set pointer = (k+1) mod 3, go to IDLE; GNT deasserts on that exit edge.
REQ-023 Request-to-M_START latency with an idle master SHALL be 3 cycles (IDLE, GRANT, LAUNCH).
REQ-024 Requests deasserted before grant SHALL be dropped silently; deassertion after grant SHALL NOT abort the transaction.
REQ-025 A requester still holding REQ in DONE SHALL be eligible again only through round-robin order.
REQ-026 M_DONE outside WAIT SHALL be ignored.
REQ-027 Any change to REQ_* inputs after GRANT SHALL NOT alter the M_* outputs.

Reset
REQ-028 On EXT_RESET = 0, asynchronously: state = IDLE, pointer = 0, GNT = 0, REQ_DONE = 0, M_START = 0, ERR = 0, RDATA = 0x00, M_ADDR/M_REG/M_WDATA/M_RW = 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no REQ_DONE pulse; after release, the FSM restarts from IDLE with pointer 0.

Configuration
REQ-030 Macro I2C_ARB_TIMEOUT_EN: when defined, a counter cleared on WAIT entry increments each WAIT cycle.
REQ-031 With I2C_ARB_TIMEOUT_EN, if the count reaches TIMEOUT_CYCLES without M_DONE, the FSM goes to DONE with ERR = 1 and RDATA unchanged.
REQ-032 With I2C_ARB_TIMEOUT_EN, if M_DONE arrives in the same cycle the count reaches TIMEOUT_CYCLES, M_DONE wins.
REQ-033 Without I2C_ARB_TIMEOUT_EN, there is no counter and WAIT exits only on M_DONE.

Verification
REQ-034 Single read: REQ = 001, addr 0x68, reg 0x3B, M_DONE with M_RDATA = 0xA5 -> M_START 3 cycles after REQ, REQ_DONE = 001, RDATA = 0xA5, ERR = 0.
REQ-035 Contention: REQ = 111 held, pointer 0 -> grant order 0, 1, 2, 0; exactly one GNT bit at any time.
REQ-036 NACK: write 0x55 by requester 2 with M_ACK_ERR = 1 at M_DONE -> REQ_DONE = 100, ERR = 1, RDATA unchanged.
REQ-037 Busy master: M_BUSY = 1 for 10 cycles during LAUNCH -> M_START is delayed to the first cycle M_BUSY = 0 and is exactly one cycle wide.
REQ-038 Reset in WAIT: EXT_RESET low for 2 cycles -> all outputs zero immediately, no REQ_DONE, next grant follows pointer 0.
REQ-039 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no M_DONE -> DONE after 16 WAIT cycles, ERR = 1.
